// File: rtl/job_dispatch_accumulator.sv
// Job dispatcher and result accumulator.
// Buffers incoming jobs in a FIFO and hands them round-robin to idle workers.
// Worker results are collected one per cycle into a running total, which is
// streamed out over a valid/ready handshake.
module job_dispatch_accumulator #(
    parameter int JOB_WIDTH    = 220,
    parameter int WORKER_COUNT = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int RESULT_WIDTH = 24,
    parameter int SUM_WIDTH    = 32,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 job_valid,
    output logic                                 job_ready,
    input  logic [JOB_WIDTH-1:0]                 job_data,
    output logic [WORKER_COUNT-1:0]              worker_start,
    output logic [JOB_WIDTH-1:0]                 worker_job,
    input  logic [WORKER_COUNT-1:0]              worker_available,
    input  logic [WORKER_COUNT-1:0]              worker_result_valid,
    input  logic [WORKER_COUNT*RESULT_WIDTH-1:0] worker_result,
    output logic                                 sum_valid,
    input  logic                                 sum_ready,
    output logic [SUM_WIDTH-1:0]                 sum_data,
    input  logic [COUNT_WIDTH-1:0]               expected_jobs,
    output logic [COUNT_WIDTH-1:0]               completed_jobs,
    output logic [$clog2(WORKER_COUNT+1)-1:0]    jobs_in_flight,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 all_done,
    output logic                                 overflow,
    output logic                                 protocol_error
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WID_W = (WORKER_COUNT > 1) ? $clog2(WORKER_COUNT) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(WORKER_COUNT + 1);

    // FIFO storage and pointers
    logic [JOB_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;

    // Per-worker tracking
    logic [WORKER_COUNT-1:0] pending;
    logic [WORKER_COUNT-1:0] busy;
    logic [WORKER_COUNT-1:0] held;
    logic [WORKER_COUNT-1:0] eligible;
    logic [WORKER_COUNT-1:0] capture;
    logic [WORKER_COUNT-1:0] stray;
    logic [RESULT_WIDTH-1:0] held_result [WORKER_COUNT];

    // Round-robin selection
    logic [WID_W-1:0]        rr_d;
    logic [WID_W-1:0]        rr_a;
    logic [WID_W-1:0]        disp_cand;
    logic [WID_W-1:0]        acc_cand;
    logic [WID_W-1:0]        disp_idx;
    logic [WID_W-1:0]        acc_idx;
    logic                    disp_found;
    logic                    acc_found;
    logic                    acc_fire;
    logic [WORKER_COUNT-1:0] disp_onehot;
    logic [WORKER_COUNT-1:0] acc_onehot;
    logic [SUM_WIDTH:0]      sum_ext;
    logic [IF_W-1:0]         in_flight_count;

    // job_ready is forced low while reset is asserted, since the level alone reads empty then
    assign job_ready = reset && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push      = job_valid && job_ready;
    assign pop       = disp_found;
    assign eligible  = worker_available & ~pending & ~busy & ~held;
    assign capture   = worker_result_valid & busy;
    assign stray     = worker_result_valid & ~busy;
    assign acc_fire  = acc_found && (!sum_valid || sum_ready);
    assign sum_ext   = {1'b0, sum_data}
                     + {{(SUM_WIDTH + 1 - RESULT_WIDTH){1'b0}}, held_result[acc_idx]};
    assign jobs_in_flight = in_flight_count;

    // Pick the first eligible worker at or after rr_d, only when a job is waiting
    always_comb begin
        disp_found  = 1'b0;
        disp_idx    = '0;
        disp_cand   = '0;
        disp_onehot = '0;
        if (fifo_level != '0) begin
            for (int k = 0; k < WORKER_COUNT; k++) begin
                disp_cand = WID_W'((int'(rr_d) + k) % WORKER_COUNT);
                if (!disp_found && eligible[disp_cand]) begin
                    disp_found = 1'b1;
                    disp_idx   = disp_cand;
                end
            end
        end
        if (disp_found) begin
            disp_onehot[disp_idx] = 1'b1;
        end
    end

    // Pick the first worker holding a result at or after rr_a
    always_comb begin
        acc_found  = 1'b0;
        acc_idx    = '0;
        acc_cand   = '0;
        acc_onehot = '0;
        for (int k = 0; k < WORKER_COUNT; k++) begin
            acc_cand = WID_W'((int'(rr_a) + k) % WORKER_COUNT);
            if (!acc_found && held[acc_cand]) begin
                acc_found = 1'b1;
                acc_idx   = acc_cand;
            end
        end
        if (acc_found) begin
            acc_onehot[acc_idx] = 1'b1;
        end
    end

    // Count workers whose job has not yet reached the accumulator
    always_comb begin
        in_flight_count = '0;
        for (int i = 0; i < WORKER_COUNT; i++) begin
            in_flight_count = in_flight_count + IF_W'(busy[i] | held[i]);
        end
    end

    // FIFO payload storage; contents are meaningless after reset since the pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= job_data;
        end
    end

    // FIFO pointers wrap at FIFO_DEPTH, which need not be a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Registered start pulse and payload; the pointer advances past the chosen worker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            worker_start <= '0;
            worker_job   <= '0;
            rr_d         <= '0;
        end else begin
            worker_start <= disp_onehot;
            if (disp_found) begin
                worker_job <= fifo_mem[rd_ptr];
                rr_d       <= WID_W'((int'(disp_idx) + 1) % WORKER_COUNT);
            end
        end
    end

    // Worker lifecycle: pending until acknowledged, busy until result, held until summed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            busy    <= '0;
            held    <= '0;
            for (int i = 0; i < WORKER_COUNT; i++) begin
                held_result[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORKER_COUNT; i++) begin
                if (disp_onehot[i]) begin
                    pending[i] <= 1'b1;
                end else if (!worker_available[i] || worker_result_valid[i]) begin
                    pending[i] <= 1'b0;
                end
                if (disp_onehot[i]) begin
                    busy[i] <= 1'b1;
                end else if (capture[i]) begin
                    busy[i] <= 1'b0;
                end
                if (capture[i]) begin
                    held[i]        <= 1'b1;
                    held_result[i] <= worker_result[i*RESULT_WIDTH +: RESULT_WIDTH];
                end else if (acc_fire && acc_onehot[i]) begin
                    held[i] <= 1'b0;
                end
            end
        end
    end

    // Running total with output handshake; a new beat replaces an accepted one with no bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_data       <= '0;
            sum_valid      <= 1'b0;
            overflow       <= 1'b0;
            completed_jobs <= '0;
            rr_a           <= '0;
        end else begin
            if (acc_fire) begin
                sum_data       <= sum_ext[SUM_WIDTH-1:0];
                sum_valid      <= 1'b1;
                completed_jobs <= completed_jobs + COUNT_WIDTH'(1);
                rr_a           <= WID_W'((int'(acc_idx) + 1) % WORKER_COUNT);
                if (sum_ext[SUM_WIDTH]) begin
                    overflow <= 1'b1;
                end
            end else if (sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end

    // Sticky error on strobes from idle workers, and a registered completion flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            protocol_error <= 1'b0;
            all_done       <= 1'b0;
        end else begin
            if (|stray) begin
                protocol_error <= 1'b1;
            end
            all_done <= (expected_jobs != '0) && (completed_jobs == expected_jobs)
                     && (fifo_level == '0) && (in_flight_count == '0);
        end
    end

endmodule

// File: tb/tb_job_dispatch_accumulator.sv
// Directed testbench for job_dispatch_accumulator.
// One instance with a small FIFO and 8-bit sum so that full-FIFO and
// accumulator-wrap cases are reachable; workers are driven by hand.
module tb_job_dispatch_accumulator;

    localparam int JW = 16;
    localparam int WC = 4;
    localparam int FD = 4;
    localparam int RW = 8;
    localparam int SW = 8;
    localparam int CW = 16;

    logic              clk;
    logic              reset;
    logic              job_valid;
    logic              job_ready;
    logic [JW-1:0]     job_data;
    logic [WC-1:0]     worker_start;
    logic [JW-1:0]     worker_job;
    logic [WC-1:0]     worker_available;
    logic [WC-1:0]     worker_result_valid;
    logic [WC*RW-1:0]  worker_result;
    logic              sum_valid;
    logic              sum_ready;
    logic [SW-1:0]     sum_data;
    logic [CW-1:0]     expected_jobs;
    logic [CW-1:0]     completed_jobs;
    logic [2:0]        jobs_in_flight;
    logic [2:0]        fifo_level;
    logic              all_done;
    logic              overflow;
    logic              protocol_error;

    int passed = 0;
    int total  = 0;

    job_dispatch_accumulator #(
        .JOB_WIDTH    (JW),
        .WORKER_COUNT (WC),
        .FIFO_DEPTH   (FD),
        .RESULT_WIDTH (RW),
        .SUM_WIDTH    (SW),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .job_data            (job_data),
        .worker_start        (worker_start),
        .worker_job          (worker_job),
        .worker_available    (worker_available),
        .worker_result_valid (worker_result_valid),
        .worker_result       (worker_result),
        .sum_valid           (sum_valid),
        .sum_ready           (sum_ready),
        .sum_data            (sum_data),
        .expected_jobs       (expected_jobs),
        .completed_jobs      (completed_jobs),
        .jobs_in_flight      (jobs_in_flight),
        .fifo_level          (fifo_level),
        .all_done            (all_done),
        .overflow            (overflow),
        .protocol_error      (protocol_error)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        job_valid           = 1'b0;
        worker_result_valid = '0;
        worker_available    = '0;
        reset               = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset               = 1'b0;
        job_valid           = 1'b0;
        job_data            = '0;
        worker_available    = '0;
        worker_result_valid = '0;
        worker_result       = '0;
        sum_ready           = 1'b0;
        expected_jobs       = '0;

        // ---------------- reset state ----------------
        #12;
        check_output("rst_job_ready",   32'(job_ready),      32'd0);
        check_output("rst_start",       32'(worker_start),   32'd0);
        check_output("rst_job",         32'(worker_job),     32'd0);
        check_output("rst_sum_valid",   32'(sum_valid),      32'd0);
        check_output("rst_sum_data",    32'(sum_data),       32'd0);
        check_output("rst_completed",   32'(completed_jobs), 32'd0);
        check_output("rst_in_flight",   32'(jobs_in_flight), 32'd0);
        check_output("rst_level",       32'(fifo_level),     32'd0);
        check_output("rst_all_done",    32'(all_done),       32'd0);
        check_output("rst_overflow",    32'(overflow),       32'd0);
        check_output("rst_perr",        32'(protocol_error), 32'd0);
        reset = 1'b1;
        tick();
        check_output("rel_job_ready", 32'(job_ready), 32'd1);

        // ---------------- test 1: single job ----------------
        expected_jobs    = 16'd1;
        worker_available = 4'b1111;
        sum_ready        = 1'b0;
        job_valid        = 1'b1;
        job_data         = 16'hA001;
        tick();
        check_output("t1_level_after_push", 32'(fifo_level),   32'd1);
        check_output("t1_no_early_start",   32'(worker_start), 32'd0);
        job_valid = 1'b0;
        tick();
        check_output("t1_start",     32'(worker_start),   32'b0001);
        check_output("t1_job",       32'(worker_job),     32'hA001);
        check_output("t1_level",     32'(fifo_level),     32'd0);
        check_output("t1_in_flight", 32'(jobs_in_flight), 32'd1);
        worker_result_valid = 4'b0001;
        worker_result       = 32'd17;
        tick();
        worker_result_valid = '0;
        check_output("t1_no_beat_yet", 32'(sum_valid), 32'd0);
        tick();
        check_output("t1_sum",        32'(sum_data),       32'd17);
        check_output("t1_sum_valid",  32'(sum_valid),      32'd1);
        check_output("t1_completed",  32'(completed_jobs), 32'd1);
        check_output("t1_in_flight0", 32'(jobs_in_flight), 32'd0);
        check_output("t1_done_lag",   32'(all_done),       32'd0);
        tick();
        check_output("t1_all_done",   32'(all_done),  32'd1);
        check_output("t1_sum_hold",   32'(sum_valid), 32'd1);
        expected_jobs = 16'd2;
        tick();
        check_output("t1_done_drops", 32'(all_done), 32'd0);

        // ---------------- test 2: six jobs round-robin ----------------
        apply_reset();
        expected_jobs    = 16'd0;
        worker_available = 4'b1111;
        sum_ready        = 1'b1;
        job_valid        = 1'b1;
        job_data         = 16'h0201;
        tick();
        check_output("t2_level1", 32'(fifo_level), 32'd1);
        job_data = 16'h0202;
        tick();
        check_output("t2_start_w0", 32'(worker_start), 32'b0001);
        check_output("t2_job_w0",   32'(worker_job),   32'h0201);
        worker_available[0] = 1'b0;
        job_data            = 16'h0203;
        tick();
        check_output("t2_start_w1", 32'(worker_start), 32'b0010);
        check_output("t2_job_w1",   32'(worker_job),   32'h0202);
        worker_available[1] = 1'b0;
        job_data            = 16'h0204;
        tick();
        check_output("t2_start_w2", 32'(worker_start), 32'b0100);
        worker_available[2] = 1'b0;
        job_data            = 16'h0205;
        tick();
        check_output("t2_start_w3", 32'(worker_start), 32'b1000);
        check_output("t2_job_w3",   32'(worker_job),   32'h0204);
        worker_available[3] = 1'b0;
        job_data            = 16'h0206;
        tick();
        check_output("t2_no_start",  32'(worker_start),   32'd0);
        check_output("t2_level2",    32'(fifo_level),     32'd2);
        check_output("t2_in_flight", 32'(jobs_in_flight), 32'd4);
        job_valid           = 1'b0;
        worker_result_valid = 4'b0001;
        worker_result       = 32'h0000_0001;
        worker_available[0] = 1'b1;
        tick();
        check_output("t2_held_not_eligible", 32'(worker_start), 32'd0);
        worker_result_valid = 4'b0010;
        worker_result       = 32'h0000_0200;
        worker_available[1] = 1'b1;
        tick();
        check_output("t2_beat1", 32'(sum_data),  32'd1);
        check_output("t2_v1",    32'(sum_valid), 32'd1);
        worker_result_valid = 4'b0100;
        worker_result       = 32'h0003_0000;
        worker_available[2] = 1'b1;
        tick();
        check_output("t2_beat3",      32'(sum_data),     32'd3);
        check_output("t2_restart_w0", 32'(worker_start), 32'b0001);
        check_output("t2_job5",       32'(worker_job),   32'h0205);
        worker_result_valid = 4'b1000;
        worker_result       = 32'h0400_0000;
        worker_available[3] = 1'b1;
        worker_available[0] = 1'b0;
        tick();
        check_output("t2_beat6",      32'(sum_data),     32'd6);
        check_output("t2_restart_w1", 32'(worker_start), 32'b0010);
        check_output("t2_job6",       32'(worker_job),   32'h0206);
        check_output("t2_level0",     32'(fifo_level),   32'd0);
        worker_result_valid = '0;
        worker_available[1] = 1'b0;
        tick();
        check_output("t2_beat10", 32'(sum_data), 32'd10);
        worker_result_valid = 4'b0001;
        worker_result       = 32'h0000_0005;
        worker_available[0] = 1'b1;
        tick();
        check_output("t2_gap", 32'(sum_valid), 32'd0);
        worker_result_valid = 4'b0010;
        worker_result       = 32'h0000_0600;
        worker_available[1] = 1'b1;
        tick();
        check_output("t2_beat15", 32'(sum_data),  32'd15);
        check_output("t2_v15",    32'(sum_valid), 32'd1);
        worker_result_valid = '0;
        tick();
        check_output("t2_beat21",     32'(sum_data),       32'd21);
        check_output("t2_completed",  32'(completed_jobs), 32'd6);
        check_output("t2_in_flight0", 32'(jobs_in_flight), 32'd0);

        // ---------------- test 3: FIFO full ----------------
        apply_reset();
        worker_available = 4'b0000;
        sum_ready        = 1'b1;
        job_valid        = 1'b1;
        job_data         = 16'h0301;
        tick();
        check_output("t3_level1", 32'(fifo_level), 32'd1);
        check_output("t3_ready1", 32'(job_ready),  32'd1);
        job_data = 16'h0302;
        tick();
        job_data = 16'h0303;
        tick();
        job_data = 16'h0304;
        tick();
        check_output("t3_level_full", 32'(fifo_level), 32'd4);
        check_output("t3_ready_low",  32'(job_ready),  32'd0);
        job_data = 16'h0305;
        tick();
        check_output("t3_stalled",  32'(fifo_level),   32'd4);
        check_output("t3_no_start", 32'(worker_start), 32'd0);
        worker_available = 4'b0100;
        tick();
        check_output("t3_start_w2", 32'(worker_start), 32'b0100);
        check_output("t3_job",      32'(worker_job),   32'h0301);
        check_output("t3_level3",   32'(fifo_level),   32'd3);
        check_output("t3_ready_up", 32'(job_ready),    32'd1);
        worker_available = 4'b0000;
        tick();
        job_valid = 1'b0;
        check_output("t3_fifth_in", 32'(fifo_level), 32'd4);
        check_output("t3_ready_lo2", 32'(job_ready), 32'd0);

        // ---------------- test 4: simultaneous results, backpressure ----------------
        apply_reset();
        worker_available = 4'b0111;
        sum_ready        = 1'b0;
        job_valid        = 1'b1;
        job_data         = 16'h0401;
        tick();
        job_data = 16'h0402;
        tick();
        job_data = 16'h0403;
        tick();
        job_valid = 1'b0;
        tick();
        check_output("t4_start_w2",  32'(worker_start),   32'b0100);
        check_output("t4_in_flight", 32'(jobs_in_flight), 32'd3);
        worker_result_valid = 4'b0111;
        worker_result       = 32'h0009_0005;
        tick();
        worker_result_valid = '0;
        check_output("t4_captured", 32'(sum_valid),      32'd0);
        check_output("t4_held3",    32'(jobs_in_flight), 32'd3);
        tick();
        check_output("t4_beat5",  32'(sum_data),       32'd5);
        check_output("t4_v",      32'(sum_valid),      32'd1);
        check_output("t4_cnt1",   32'(completed_jobs), 32'd1);
        tick();
        check_output("t4_stable",  32'(sum_data),       32'd5);
        check_output("t4_stable_v", 32'(sum_valid),     32'd1);
        check_output("t4_cnt_hold", 32'(completed_jobs), 32'd1);
        sum_ready = 1'b1;
        tick();
        check_output("t4_beat5_zero", 32'(sum_data),       32'd5);
        check_output("t4_no_bubble",  32'(sum_valid),      32'd1);
        check_output("t4_cnt2",       32'(completed_jobs), 32'd2);
        tick();
        check_output("t4_beat14", 32'(sum_data),       32'd14);
        check_output("t4_v14",    32'(sum_valid),      32'd1);
        check_output("t4_cnt3",   32'(completed_jobs), 32'd3);
        tick();
        check_output("t4_drained", 32'(sum_valid),      32'd0);
        check_output("t4_idle",    32'(jobs_in_flight), 32'd0);

        // ---------------- test 5: accumulator wrap and protocol error ----------------
        apply_reset();
        worker_available = 4'b0001;
        sum_ready        = 1'b1;
        job_valid        = 1'b1;
        job_data         = 16'h0501;
        tick();
        job_valid = 1'b0;
        tick();
        check_output("t5_start1", 32'(worker_start), 32'b0001);
        worker_result_valid = 4'b0001;
        worker_result       = 32'd200;
        tick();
        worker_result_valid = '0;
        tick();
        check_output("t5_sum200", 32'(sum_data), 32'd200);
        check_output("t5_no_ovf", 32'(overflow), 32'd0);
        job_valid = 1'b1;
        job_data  = 16'h0502;
        tick();
        job_valid = 1'b0;
        tick();
        check_output("t5_start2", 32'(worker_start), 32'b0001);
        check_output("t5_job2",   32'(worker_job),   32'h0502);
        worker_result_valid = 4'b0001;
        worker_result       = 32'd100;
        tick();
        worker_result_valid = '0;
        tick();
        check_output("t5_sum_wrap", 32'(sum_data), 32'd44);
        check_output("t5_ovf",      32'(overflow), 32'd1);
        tick();
        check_output("t5_ovf_sticky", 32'(overflow),  32'd1);
        check_output("t5_idle_v",     32'(sum_valid), 32'd0);
        worker_result_valid = 4'b0010;
        worker_result       = 32'h0000_4D00;
        tick();
        worker_result_valid = '0;
        check_output("t5_perr", 32'(protocol_error), 32'd1);
        tick();
        check_output("t5_sum_unchanged", 32'(sum_data),       32'd44);
        check_output("t5_cnt",           32'(completed_jobs), 32'd2);
        check_output("t5_perr_sticky",   32'(protocol_error), 32'd1);

        // ---------------- test 6: reset mid-run ----------------
        apply_reset();
        worker_available = 4'b0011;
        sum_ready        = 1'b1;
        job_valid        = 1'b1;
        job_data         = 16'h0601;
        tick();
        job_data = 16'h0602;
        tick();
        job_data = 16'h0603;
        tick();
        job_data = 16'h0604;
        tick();
        job_data = 16'h0605;
        tick();
        job_valid = 1'b0;
        check_output("t6_level3",    32'(fifo_level),     32'd3);
        check_output("t6_in_flight", 32'(jobs_in_flight), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_output("t6_async_level",  32'(fifo_level),     32'd0);
        check_output("t6_async_ready",  32'(job_ready),      32'd0);
        check_output("t6_async_flight", 32'(jobs_in_flight), 32'd0);
        check_output("t6_async_start",  32'(worker_start),   32'd0);
        tick();
        reset            = 1'b1;
        worker_available = 4'b0000;
        tick();
        check_output("t6_rel_level", 32'(fifo_level), 32'd0);
        check_output("t6_rel_ready", 32'(job_ready),  32'd1);
        check_output("t6_rel_perr",  32'(protocol_error), 32'd0);
        worker_result_valid = 4'b0011;
        worker_result       = 32'h0000_0302;
        tick();
        worker_result_valid = '0;
        check_output("t6_stale_perr",   32'(protocol_error), 32'd1);
        check_output("t6_stale_no_sum", 32'(sum_valid),      32'd0);
        check_output("t6_stale_flight", 32'(jobs_in_flight), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
